// File: rtl/stdout_fifo_if.sv
// Handshake bundle between the CPU write port, the UART read port and the stdout FIFO.
// DEPTH must match the FIFO instance so that count has the same width on both sides.
interface stdout_fifo_if #(
  parameter int unsigned DEPTH = 1024
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          cpu_write_enable;
  logic [7:0]    cpu_write_data;
  logic          cpu_write_ready;
  logic          stdout_memory_read_enable;
  logic          stdout_memory_read_ready;
  logic [7:0]    stdout_memory_read_data;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output flush,
    output cpu_write_enable,
    output cpu_write_data,
    output stdout_memory_read_enable,
    input  cpu_write_ready,
    input  stdout_memory_read_ready,
    input  stdout_memory_read_data,
    input  count,
    input  overflow
  );

  modport slave (
    input  flush,
    input  cpu_write_enable,
    input  cpu_write_data,
    input  stdout_memory_read_enable,
    output cpu_write_ready,
    output stdout_memory_read_ready,
    output stdout_memory_read_data,
    output count,
    output overflow
  );
endinterface

// File: rtl/stdout_fifo.sv
// Byte FIFO between the CPU and the UART transmitter: show-ahead head byte,
// sticky overflow on dropped writes, synchronous flush and active-low reset.
module stdout_fifo #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  stdout_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 65536) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stdout_fifo: DEPTH must be a power of two in 2..65536");
  end

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // Full/empty come from the registered count, so a pop never frees room for a same-cycle push.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.cpu_write_enable && !w_full && !bus.flush;
  assign w_pop   = bus.stdout_memory_read_enable && !w_empty && !bus.flush;
  assign w_drop  = bus.cpu_write_enable && w_full && !bus.flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.cpu_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.cpu_write_ready          = !w_full;
  assign bus.stdout_memory_read_ready = !w_empty && !bus.stdout_memory_read_enable;
  assign bus.stdout_memory_read_data  = r_mem[r_rd_ptr];
  assign bus.count                    = r_count;
  assign bus.overflow                 = r_overflow;

  // Occupancy must always agree with the pointer distance (full when pointers meet with count==DEPTH).
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (r_count <= C_DEPTH);
      assert (r_count[AW-1:0] == AW'(r_wr_ptr - r_rd_ptr));
    end
  end
endmodule

// File: doc/stdout_fifo.md
STDOUT_FIFO -- requirements
Module: stdout_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning buffer capacity in bytes; legal values are powers of two, 2..65536.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port flush, input, 1 bit: synchronous clear of buffer contents.
REQ-005 SHALL have port cpu_write_enable, input, 1 bit: one-cycle request from the CPU to push one byte.
REQ-006 SHALL have port cpu_write_data, input, 8 bits: the byte to push.
REQ-007 SHALL have port cpu_write_ready, output, 1 bit: high when count < DEPTH.
REQ-008 SHALL have port stdout_memory_read_enable, input, 1 bit: one-cycle pop strobe from the UART controller.
REQ-009 SHALL have port stdout_memory_read_ready, output, 1 bit: head byte available to the UART controller.
REQ-010 SHALL have port stdout_memory_read_data, output, 8 bits: the head byte, presented first-word-fall-through.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1 bits: number of stored bytes.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag set when a write is dropped.

Function
REQ-013 Storage SHALL be a circular buffer with read and write pointers of clog2(DEPTH) bits each; both pointers wrap from DEPTH-1 to 0.
REQ-014 Push: a byte SHALL be accepted at the clock edge where cpu_write_enable=1 and count<DEPTH (count as registered at cycle start).
  - On accept: the byte is stored at the write pointer and the write pointer increments.
REQ-015 A write while count==DEPTH SHALL be dropped and SHALL set overflow; this holds even if a pop occurs in the same cycle.
REQ-016 Pop: at the clock edge where stdout_memory_read_enable=1 and count>0, the read pointer SHALL increment.
  - A pop strobe while count==0 is ignored, with no state change.
REQ-017 stdout_memory_read_data SHALL equal the byte at the read pointer whenever count>0 (show-ahead; no read latency).
  - When count==0 the value is don't-care.
REQ-018 stdout_memory_read_ready SHALL equal (count>0) AND NOT stdout_memory_read_enable, combinationally gated.
  - This prevents a second sample of a stale head in the pop cycle.
REQ-019 Simultaneous accepted push and pop SHALL leave count unchanged and move both pointers.
  - With count==0, a push makes data visible one cycle later; the same-cycle pop is ignored per REQ-016.
REQ-020 count SHALL update per accepted push (+1) and pop (-1) at the same edge; count SHALL never exceed DEPTH or go below 0.
REQ-021 cpu_write_ready SHALL be combinational from registered count.
REQ-022 flush=1 SHALL, at the next edge, zero both pointers and count; overflow SHALL be unchanged.
  - Push/pop in the same cycle are discarded.
REQ-023 overflow SHALL clear only on reset.
REQ-024 Storage array contents SHALL need no reset.

Reset
REQ-025 With reset_n=0 at an edge: pointers=0, count=0, overflow=0; reset SHALL take priority over flush, push and pop.
REQ-026 During and after reset until the first push: cpu_write_ready=1, stdout_memory_read_ready=0.
REQ-027 Reset mid-operation SHALL discard all stored bytes; no byte is presented after reset until a new push.

Verification
REQ-028 Push 0x41,0x42,0x43 on consecutive cycles, no pops -> count=3, read_ready=1, read_data=0x41.
  - Then three spaced pops -> read_data 0x42, 0x43, then read_ready=0, count=0.
REQ-029 DEPTH=4: push 5 bytes 0x10..0x14 -> cpu_write_ready=0 after the 4th push, 0x14 dropped, overflow=1.
  - Drain -> 0x10..0x13 in order; overflow stays 1.
REQ-030 With count=4 (full), push and pop in the same cycle -> pop accepted, push dropped, count=3, overflow=1.
  - With count=2, push and pop together -> count stays 2 and order is preserved.
REQ-031 DEPTH=4: push/pop 10 bytes 0x00..0x09 keeping count<=2 -> pointers wrap and every byte emerges in order.
  - read_ready is low in every cycle where read_enable=1.
REQ-032 Pop with count=0 -> no change.
  - flush with count=3 -> count=0, read_ready=0, next push visible next cycle.
  - reset_n=0 with count=2, overflow=1 -> count=0, overflow=0.
REQ-033 Connected to the UART controller with a model UART_TX: push "Hi\n" (0x48,0x69,0x0A) -> exactly three frames transmitted in that order, no duplicates.
